// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline inter-stage registers.
//
// Contents:
//   stage_state_e   occupancy of a stage register (EMPTY / ONE / FULL beats held)
//   *_CTRL_W/_DATA_W widths for the IF/ID, ID/EX, EX/MEM and MEM/WB instances
//   *_BUBBLE_CTRL   control value each stage presents while it holds a bubble
//   holdsBeat()     true when a state has a beat in the main (head) slot
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int IFID_CTRL_W  = 8;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 16;
  localparam int IDEX_DATA_W  = 96;
  localparam int EXMEM_CTRL_W = 12;
  localparam int EXMEM_DATA_W = 96;
  localparam int MEMWB_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 64;

  // Bubbles must decode as "do nothing" in the consuming stage.
  localparam logic [IFID_CTRL_W-1:0]  IFID_BUBBLE_CTRL  = 8'h00;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_BUBBLE_CTRL  = 16'h0013;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_BUBBLE_CTRL = 12'h000;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_BUBBLE_CTRL = 8'h00;

  function automatic logic holdsBeat(stage_state_e s);
    return (s != EMPTY);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: width-parametrised saturating event counter.
//
// Ports:
//   clk      in   clock; updates on the falling edge like the pipeline registers
//   reset_n  in   asynchronous active-low reset, clears the count
//   inc      in   count one event this cycle
//   count    out  current count, sticks at all-ones
module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] INC_STEP = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Stop at all-ones so a long stall never wraps back to a small value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + INC_STEP;
    end
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid/ready
// handshake, optional one-entry skid buffer, and control-unit stall/flush.
//
// Ports:
//   clk        in   stage clock, state updates on the falling edge
//   reset_n    in   asynchronous active-low reset
//   cu_stall   in   freeze the stage (dominates cu_flush)
//   cu_flush   in   drop all held beats and present a bubble
//   in_valid   in   upstream beat available
//   in_ready   out  stage can accept (from a flop when SKID_EN=1)
//   in_ctrl    in   upstream control field   [CTRL_W]
//   in_data    in   upstream payload         [DATA_W]
//   out_valid  out  head beat valid
//   out_ready  in   downstream accepts
//   out_ctrl   out  head control, BUBBLE_CTRL when empty
//   out_data   out  head payload, 0 when empty
//   stall_cnt  out  stalled cycles           [CNT_W]
//   flush_cnt  out  effective flushes        [CNT_W]
//
// Build option: define PIPE_STAGE_PERF_EN to include the stall/flush
// performance counters; otherwise both counter outputs are tied to 0.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              CTRL_W      = 16,
  parameter int              DATA_W      = 96,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit              SKID_EN     = 1'b1,
  parameter int              CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cu_stall,
  input  logic              cu_flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_state_e      state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic main_valid;
  logic skid_valid;
  logic in_xfer;
  logic out_xfer;

  assign main_valid = holdsBeat(state_q);
  assign skid_valid = (state_q == FULL);

  // With the skid slot, ready depends only on our own state (plus the stall
  // override), so downstream backpressure never ripples combinationally
  // upstream. Without it, ready must look at out_ready to keep throughput.
  assign in_ready = SKID_EN ? (!cu_stall && !skid_valid)
                            : (!cu_stall && (out_ready || !main_valid));

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready && !cu_stall;

  // Next-state: stall holds everything, flush empties the stage, otherwise
  // move beats by occupancy. Main is always the head, skid the tail.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (!cu_stall) begin
      if (cu_flush) begin
        state_d     = EMPTY;
        main_ctrl_d = BUBBLE_CTRL;
        main_data_d = '0;
        skid_ctrl_d = BUBBLE_CTRL;
        skid_data_d = '0;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
              state_d     = ONE;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end else if (out_xfer) begin
              state_d = EMPTY;
            end else if (in_xfer) begin
              if (SKID_EN) begin
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
                state_d     = FULL;
              end else begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
              end
            end
          end
          FULL: begin
            if (out_xfer) begin
              main_ctrl_d = skid_ctrl_q;
              main_data_d = skid_data_q;
              state_d     = ONE;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_ctrl_q <= BUBBLE_CTRL;
      main_data_q <= '0;
      skid_ctrl_q <= BUBBLE_CTRL;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Gate on valid so a drained head never leaks its stale payload.
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl_q : BUBBLE_CTRL;
  assign out_data  = main_valid ? main_data_q : '0;

`ifdef PIPE_STAGE_PERF_EN
  logic flush_hit;
  assign flush_hit = cu_flush && !cu_stall;

  pipe_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cu_stall),
    .count   (stall_cnt)
  );

  pipe_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (flush_hit),
    .count   (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: bench for pipe_stage_reg. Instance A uses the skid
// buffer (ID/EX widths), instance B is the single-entry variant with a
// narrow counter so saturation is reached. Expected behaviour comes from
// queue models of each stage. Honours PIPE_STAGE_PERF_EN for the counters.
module tb_pipe_stage_reg;

  localparam int CW    = 16;
  localparam int DW    = 96;
  localparam int CNT_A = 16;
  localparam int CNT_B = 4;
  localparam logic [CW-1:0] BUB_A = pipe_pkg::IDEX_BUBBLE_CTRL;
  localparam logic [CW-1:0] BUB_B = 16'h00A5;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic            aStall, aFlush, aInValid, aInReady, aOutValid, aOutReady;
  logic [CW-1:0]   aInCtrl, aOutCtrl;
  logic [DW-1:0]   aInData, aOutData;
  logic [CNT_A-1:0] aStallCnt, aFlushCnt;

  logic            bStall, bFlush, bInValid, bInReady, bOutValid, bOutReady;
  logic [CW-1:0]   bInCtrl, bOutCtrl;
  logic [DW-1:0]   bInData, bOutData;
  logic [CNT_B-1:0] bStallCnt, bFlushCnt;

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .BUBBLE_CTRL(BUB_A), .SKID_EN(1'b1), .CNT_W(CNT_A)
  ) dutA (
    .clk(clk), .reset_n(reset_n), .cu_stall(aStall), .cu_flush(aFlush),
    .in_valid(aInValid), .in_ready(aInReady), .in_ctrl(aInCtrl), .in_data(aInData),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_ctrl(aOutCtrl), .out_data(aOutData),
    .stall_cnt(aStallCnt), .flush_cnt(aFlushCnt)
  );

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .BUBBLE_CTRL(BUB_B), .SKID_EN(1'b0), .CNT_W(CNT_B)
  ) dutB (
    .clk(clk), .reset_n(reset_n), .cu_stall(bStall), .cu_flush(bFlush),
    .in_valid(bInValid), .in_ready(bInReady), .in_ctrl(bInCtrl), .in_data(bInData),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_ctrl(bOutCtrl), .out_data(bOutData),
    .stall_cnt(bStallCnt), .flush_cnt(bFlushCnt)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Reference models: a queue of held beats per stage plus event counts.
  beat_t aQ[$];
  beat_t bQ[$];
  int aStallM = 0, aFlushM = 0, bStallM = 0, bFlushM = 0;

  function automatic int expCnt(int m);
`ifdef PIPE_STAGE_PERF_EN
    return m;
`else
    return 0 * m;
`endif
  endfunction

  function automatic int satInc(int v, int w);
    return (v < (1 << w) - 1) ? v + 1 : v;
  endfunction

  // Stage A holds up to two beats; a beat is accepted whenever fewer than two are held.
  task automatic modelEdgeA();
    bit push, pop;
    beat_t b;
    if (!reset_n) begin
      aQ.delete(); aStallM = 0; aFlushM = 0;
    end else if (aStall) begin
      aStallM = satInc(aStallM, CNT_A);
    end else if (aFlush) begin
      aQ.delete(); aFlushM = satInc(aFlushM, CNT_A);
    end else begin
      push = aInValid && (aQ.size() < 2);
      pop  = aOutReady && (aQ.size() > 0);
      if (pop) void'(aQ.pop_front());
      if (push) begin b.c = aInCtrl; b.d = aInData; aQ.push_back(b); end
    end
  endtask

  // Stage B holds one beat; it accepts when empty or when the head leaves now.
  task automatic modelEdgeB();
    bit push, pop;
    beat_t b;
    if (!reset_n) begin
      bQ.delete(); bStallM = 0; bFlushM = 0;
    end else if (bStall) begin
      bStallM = satInc(bStallM, CNT_B);
    end else if (bFlush) begin
      bQ.delete(); bFlushM = satInc(bFlushM, CNT_B);
    end else begin
      push = bInValid && (bOutReady || bQ.size() == 0);
      pop  = bOutReady && (bQ.size() > 0);
      if (pop) void'(bQ.pop_front());
      if (push) begin b.c = bInCtrl; b.d = bInData; bQ.push_back(b); end
    end
  endtask

  task automatic tick();
    modelEdgeA();
    modelEdgeB();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    aInValid = v; aInCtrl = c; aInData = d;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    testsRun++;
    if (aOutValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", aOutValid); end
    testsRun++;
    if (aOutCtrl !== BUB_A) begin testsFailed++; $display("[TB] FAIL reset_out_ctrl: got %h, expected %h", aOutCtrl, BUB_A); end
    testsRun++;
    if (aOutData !== '0) begin testsFailed++; $display("[TB] FAIL reset_out_data: got %h, expected 0", aOutData); end
    testsRun++;
    if (aInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", aInReady); end
    testsRun++;
    if (aStallCnt !== '0 || aFlushCnt !== '0) begin testsFailed++; $display("[TB] FAIL reset_counters: got %0d/%0d, expected 0/0", aStallCnt, aFlushCnt); end
    testsRun++;
    if (bOutValid !== 1'b0 || bOutCtrl !== BUB_B || bInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_b: got v=%b c=%h r=%b, expected v=0 c=%h r=1", bOutValid, bOutCtrl, bInReady, BUB_B); end
    reset_n = 1'b1;
    aQ.delete(); bQ.delete();
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] sent [4];
    aOutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sent[i] = CW'($urandom);
      applyStimulus(1'b1, sent[i], DW'(i + 1));
      testsRun++;
      if (aInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_in_ready: beat %0d got %b, expected 1", i + 1, aInReady); end
      tick();
      testsRun++;
      if (aOutValid !== 1'b1 || aOutData !== DW'(i + 1) || aOutCtrl !== sent[i])
        begin testsFailed++; $display("[TB] FAIL b2b_out: got v=%b d=%0d c=%h, expected v=1 d=%0d c=%h", aOutValid, aOutData, aOutCtrl, i + 1, sent[i]); end
    end
    applyStimulus(1'b0, '0, '0);
    tick();
    testsRun++;
    if (aOutValid !== 1'b0 || aOutData !== '0) begin testsFailed++; $display("[TB] FAIL b2b_drain: got v=%b d=%h, expected v=0 d=0", aOutValid, aOutData); end
  endtask

  task automatic test_backpressure();
    aOutReady = 1'b0;
    applyStimulus(1'b1, 16'h0101, DW'(32'h11));
    tick();
    applyStimulus(1'b1, 16'h0202, DW'(32'h22));
    testsRun++;
    if (aInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_ready_one: got %b, expected 1", aInReady); end
    tick();
    testsRun++;
    if (aOutValid !== 1'b1 || aOutData !== DW'(32'h11)) begin testsFailed++; $display("[TB] FAIL bp_head_a: got v=%b d=%h, expected v=1 d=11", aOutValid, aOutData); end
    testsRun++;
    if (aInReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_ready_full: got %b, expected 0", aInReady); end
    applyStimulus(1'b1, 16'h0909, DW'(32'h99));
    tick();
    tick();
    testsRun++;
    if (aOutData !== DW'(32'h11) || aOutCtrl !== 16'h0101) begin testsFailed++; $display("[TB] FAIL bp_hold: got d=%h c=%h, expected d=11 c=0101", aOutData, aOutCtrl); end
    applyStimulus(1'b0, '0, '0);
    aOutReady = 1'b1;
    tick();
    testsRun++;
    if (aOutValid !== 1'b1 || aOutData !== DW'(32'h22) || aOutCtrl !== 16'h0202) begin testsFailed++; $display("[TB] FAIL bp_head_b: got v=%b d=%h, expected v=1 d=22", aOutValid, aOutData); end
    testsRun++;
    if (aInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_ready_back: got %b, expected 1", aInReady); end
    tick();
    testsRun++;
    if (aOutValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_empty: got v=%b, expected 0", aOutValid); end
  endtask

  task automatic test_flush();
    aOutReady = 1'b0;
    applyStimulus(1'b1, 16'h0101, DW'(32'h11)); tick();
    applyStimulus(1'b1, 16'h0202, DW'(32'h22)); tick();
    aFlush = 1'b1;
    applyStimulus(1'b1, 16'h0303, DW'(32'h33));
    tick();
    aFlush = 1'b0;
    applyStimulus(1'b0, '0, '0);
    testsRun++;
    if (aOutValid !== 1'b0 || aOutCtrl !== BUB_A || aOutData !== '0) begin testsFailed++; $display("[TB] FAIL flush_bubble: got v=%b c=%h d=%h, expected v=0 c=%h d=0", aOutValid, aOutCtrl, aOutData, BUB_A); end
    testsRun++;
    if (aInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_ready: got %b, expected 1", aInReady); end
    testsRun++;
    if (aFlushCnt !== CNT_A'(expCnt(1))) begin testsFailed++; $display("[TB] FAIL flush_cnt: got %0d, expected %0d", aFlushCnt, expCnt(1)); end
    aOutReady = 1'b1;
    tick();
    testsRun++;
    if (aOutValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_dropped: got v=%b d=%h, expected v=0", aOutValid, aOutData); end
  endtask

  task automatic test_stall_flush();
    int stallBase, flushBase;
    aOutReady = 1'b0;
    applyStimulus(1'b1, 16'h0404, DW'(32'h44));
    tick();
    stallBase = aStallM;
    flushBase = aFlushM;
    aStall = 1'b1; aFlush = 1'b1; aOutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h0505, DW'(32'h55));
      testsRun++;
      if (aInReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_in_ready: cycle %0d got %b, expected 0", i, aInReady); end
      tick();
      testsRun++;
      if (aOutValid !== 1'b1 || aOutData !== DW'(32'h44) || aOutCtrl !== 16'h0404) begin testsFailed++; $display("[TB] FAIL stall_hold: got v=%b d=%h c=%h, expected v=1 d=44 c=0404", aOutValid, aOutData, aOutCtrl); end
    end
    testsRun++;
    if (aStallCnt !== CNT_A'(expCnt(stallBase + 3))) begin testsFailed++; $display("[TB] FAIL stall_cnt: got %0d, expected %0d", aStallCnt, expCnt(stallBase + 3)); end
    testsRun++;
    if (aFlushCnt !== CNT_A'(expCnt(flushBase))) begin testsFailed++; $display("[TB] FAIL stall_flush_cnt: got %0d, expected %0d", aFlushCnt, expCnt(flushBase)); end
    aStall = 1'b0;
    applyStimulus(1'b0, '0, '0);
    tick();
    aFlush = 1'b0;
    testsRun++;
    if (aOutValid !== 1'b0 || aOutCtrl !== BUB_A || aOutData !== '0) begin testsFailed++; $display("[TB] FAIL unstall_bubble: got v=%b c=%h d=%h, expected v=0 c=%h d=0", aOutValid, aOutCtrl, aOutData, BUB_A); end
    testsRun++;
    if (aFlushCnt !== CNT_A'(expCnt(flushBase + 1))) begin testsFailed++; $display("[TB] FAIL unstall_flush_cnt: got %0d, expected %0d", aFlushCnt, expCnt(flushBase + 1)); end
  endtask

  task automatic test_async_reset();
    aOutReady = 1'b0;
    applyStimulus(1'b1, 16'h0606, DW'(32'h66)); tick();
    applyStimulus(1'b1, 16'h0707, DW'(32'h77)); tick();
    applyStimulus(1'b0, '0, '0);
    testsRun++;
    if (aInReady !== 1'b0 || aOutData !== DW'(32'h66)) begin testsFailed++; $display("[TB] FAIL areset_pre_full: got r=%b d=%h, expected r=0 d=66", aInReady, aOutData); end
    #2;
    reset_n = 1'b0;
    #1;
    testsRun++;
    if (aOutValid !== 1'b0 || aOutCtrl !== BUB_A || aOutData !== '0) begin testsFailed++; $display("[TB] FAIL areset_out: got v=%b c=%h d=%h, expected v=0 c=%h d=0", aOutValid, aOutCtrl, aOutData, BUB_A); end
    testsRun++;
    if (aInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL areset_ready: got %b, expected 1", aInReady); end
    testsRun++;
    if (aStallCnt !== '0 || aFlushCnt !== '0) begin testsFailed++; $display("[TB] FAIL areset_counters: got %0d/%0d, expected 0/0", aStallCnt, aFlushCnt); end
    aQ.delete(); bQ.delete();
    aStallM = 0; aFlushM = 0; bStallM = 0; bFlushM = 0;
    @(posedge clk);
    reset_n = 1'b1;
    aOutReady = 1'b1;
    tick();
    testsRun++;
    if (aOutValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL areset_after: got v=%b, expected 0", aOutValid); end
  endtask

  task automatic test_random_skid();
    logic expV;
    logic [CW-1:0] expC;
    logic [DW-1:0] expD;
    for (int cyc = 0; cyc < 400; cyc++) begin
      aStall    = ($urandom_range(0, 99) < 5);
      aFlush    = ($urandom_range(0, 99) < 2);
      aOutReady = $urandom_range(0, 1);
      applyStimulus($urandom_range(0, 9) < 6, CW'($urandom), {$urandom, $urandom, $urandom});
      testsRun++;
      if (aInReady !== (!aStall && aQ.size() < 2)) begin testsFailed++; $display("[TB] FAIL rnd_a_in_ready: cycle %0d got %b, expected %b", cyc, aInReady, !aStall && aQ.size() < 2); end
      tick();
      expV = (aQ.size() > 0);
      expC = expV ? aQ[0].c : BUB_A;
      expD = expV ? aQ[0].d : '0;
      testsRun++;
      if (aOutValid !== expV || aOutCtrl !== expC || aOutData !== expD) begin testsFailed++; $display("[TB] FAIL rnd_a_out: cycle %0d got v=%b c=%h d=%h, expected v=%b c=%h d=%h", cyc, aOutValid, aOutCtrl, aOutData, expV, expC, expD); end
    end
    aStall = 1'b0; aFlush = 1'b0;
    applyStimulus(1'b0, '0, '0);
    testsRun++;
    if (aStallCnt !== CNT_A'(expCnt(aStallM)) || aFlushCnt !== CNT_A'(expCnt(aFlushM))) begin testsFailed++; $display("[TB] FAIL rnd_a_counters: got %0d/%0d, expected %0d/%0d", aStallCnt, aFlushCnt, expCnt(aStallM), expCnt(aFlushM)); end
  endtask

  task automatic test_random_noskid();
    int delivered = 0;
    int cyc = 0;
    logic expR, expV;
    logic [CW-1:0] expC;
    logic [DW-1:0] expD;
    while (delivered < 1000 && cyc < 20000) begin
      bStall    = ($urandom_range(0, 99) < 5);
      bFlush    = ($urandom_range(0, 99) < 1);
      bOutReady = $urandom_range(0, 1);
      bInValid  = ($urandom_range(0, 9) < 7);
      bInCtrl   = CW'($urandom);
      bInData   = {$urandom, $urandom, $urandom};
      #1;
      expR = !bStall && (bOutReady || bQ.size() == 0);
      testsRun++;
      if (bInReady !== expR) begin testsFailed++; $display("[TB] FAIL rnd_b_in_ready: cycle %0d got %b, expected %b", cyc, bInReady, expR); end
      if (!bStall && !bFlush && bOutReady && bQ.size() > 0) delivered++;
      tick();
      cyc++;
      expV = (bQ.size() > 0);
      expC = expV ? bQ[0].c : BUB_B;
      expD = expV ? bQ[0].d : '0;
      testsRun++;
      if (bOutValid !== expV || bOutCtrl !== expC || bOutData !== expD) begin testsFailed++; $display("[TB] FAIL rnd_b_out: cycle %0d got v=%b c=%h d=%h, expected v=%b c=%h d=%h", cyc, bOutValid, bOutCtrl, bOutData, expV, expC, expD); end
    end
    bStall = 1'b0; bFlush = 1'b0; bInValid = 1'b0;
    testsRun++;
    if (delivered < 1000) begin testsFailed++; $display("[TB] FAIL rnd_b_budget: got %0d beats, expected 1000", delivered); end
    testsRun++;
    if (bStallCnt !== CNT_B'(expCnt(bStallM)) || bFlushCnt !== CNT_B'(expCnt(bFlushM))) begin testsFailed++; $display("[TB] FAIL rnd_b_counters: got %0d/%0d, expected %0d/%0d", bStallCnt, bFlushCnt, expCnt(bStallM), expCnt(bFlushM)); end
  endtask

  initial begin
    reset_n = 1'b0;
    aStall = 1'b0; aFlush = 1'b0; aInValid = 1'b0; aInCtrl = '0; aInData = '0; aOutReady = 1'b0;
    bStall = 1'b0; bFlush = 1'b0; bInValid = 1'b0; bInCtrl = '0; bInData = '0; bOutReady = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_stall_flush();
    test_async_reset();
    test_random_skid();
    test_random_noskid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register, the successor to the fixed-field ID/EX-style registers. It carries a control vector and a data payload across a stage boundary with a valid/ready handshake. It includes a one-entry skid buffer, so backpressure does not create a combinational ready path. Stall and flush inputs come from the control unit (cu), with stall dominating flush.

Parameters:
CTRL_W, 16, width of the control field; every bit is forced to BUBBLE_CTRL on flush or reset.
DATA_W, 96, width of the payload (pc, operands, immediates); zeroed on flush or reset.
BUBBLE_CTRL, 0, control value presented while the stage holds a bubble.
SKID_EN, 1, 1 = two-entry (main + skid) storage; 0 = single entry with in_ready = out_ready | !out_valid.
CNT_W, 16, width of the optional performance counters.

Ports:
clk  in  1  stage clock; all state updates on the falling edge, matching the pipeline register timing.
reset_n  in  1  asynchronous, active-low reset.
cu_stall  in  1  freeze the stage; no state changes.
cu_flush  in  1  discard contents, insert a bubble; ignored while cu_stall=1.
in_valid  in  1  upstream has a beat.
in_ready  out  1  stage can accept a beat; registered when SKID_EN=1.
in_ctrl  in  CTRL_W  upstream control field.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  stage holds a valid beat.
out_ready  in  1  downstream accepts.
out_ctrl  out  CTRL_W  control of the head beat; BUBBLE_CTRL when out_valid=0.
out_data  out  DATA_W  payload of the head beat; 0 when out_valid=0.
stall_cnt  out  CNT_W  cycles with cu_stall=1 (optional feature).
flush_cnt  out  CNT_W  effective flushes (optional feature).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - main_valid=0, skid_valid=0.
  - out_ctrl=BUBBLE_CTRL, out_data=0, in_ready=1.
  - Counters cleared to 0.
  - Reset mid-transfer drops the beat with no partial update.
- Transfer definitions: an input transfer is in_valid & in_ready & !cu_stall; an output transfer is out_valid & out_ready & !cu_stall.
- Priority on each falling edge: reset > cu_stall > cu_flush > normal.
- cu_stall=1:
  - All registers hold; in_ready is driven 0 and no transfer occurs.
  - out_valid/out_ctrl/out_data keep their values.
  - cu_flush is ignored; the cu must hold flush until stall drops.
- cu_flush=1 with cu_stall=0:
  - main_valid and skid_valid are cleared; ctrl=BUBBLE_CTRL, data=0.
  - Any simultaneous input beat is dropped. in_ready=1 on the next cycle.
- Normal operation, SKID_EN=1 (states EMPTY, ONE, FULL by valid count):
  - EMPTY: an input transfer loads main -> ONE. in_ready=1.
  - ONE, with both input and output transfer: main takes the input, stays ONE.
  - ONE, output transfer only -> EMPTY.
  - ONE, input transfer only: the beat goes to skid -> FULL; in_ready=0 next cycle.
  - FULL: in_ready=0. On an output transfer, skid moves to main -> ONE; in_ready=1 next cycle.
  - Single-cycle latency in -> out; full throughput with out_ready held high.
- Normal operation, SKID_EN=0:
  - Single register; in_ready = !cu_stall & (out_ready | !main_valid) is combinational.
  - A transfer loads main; an output transfer alone clears main_valid.
- Beats are never duplicated, reordered or lost except by flush or reset.
- in_ctrl/in_data are don't-care when in_valid=0.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each falling edge with cu_stall=1.
  - flush_cnt increments on each effective flush (cu_flush & !cu_stall).
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: no counter flops; stall_cnt and flush_cnt are tied to 0.

Decomposition:
- Shared package pipe_pkg holds:
  - stage state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - per-stage CTRL_W/DATA_W constants for the IF/ID, ID/EX, EX/MEM and MEM/WB instances;
  - BUBBLE_CTRL values per stage.
- One natural sub-module, pipe_sat_counter (width-parametrised saturating counter), instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
1. Reset released, out_ready=1, 4 beats with in_data=1..4 back to back -> out_data 1,2,3,4 one cycle later each; out_valid continuous; in_ready=1 throughout.
2. out_ready=0 while sending beats A=0x11, B=0x22 -> A held at the output; B goes to skid and in_ready drops to 0. Raise out_ready -> A then B emitted, in_ready returns to 1, no loss.
3. FULL with A/B, assert cu_flush for 1 cycle with in_valid=1 and C=0x33 -> out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0; C dropped; flush_cnt=1.
4. Assert cu_stall and cu_flush together for 3 cycles while ONE holds 0x44 -> outputs unchanged, in_ready=0, stall_cnt=3, flush_cnt unchanged. Drop stall with flush still high -> bubble inserted.
5. Pull reset_n low between falling edges while FULL -> outputs reset immediately, before the next edge; counters read 0.
6. SKID_EN=0 instance, random out_ready at 50% over 1000 beats -> scoreboard matches in order; in_ready equals out_ready | !out_valid every cycle.
